// File: rtl/uart_rx_pkg.sv
// Shared state encoding and sizing constants for the UART receive controller.
package uart_rx_pkg;

  localparam int unsigned DATA_LENGTH_DEF = 8;
  localparam int unsigned PRESC_W_DEF     = 6;
  localparam int unsigned MIN_PRESCALE    = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// Serial line, configuration and parity-checker handshake of the UART receiver.
interface uart_rx_if
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_LENGTH = DATA_LENGTH_DEF,
  parameter int unsigned PRESC_W     = PRESC_W_DEF
);

  logic                   RX_IN;
  logic                   PAR_EN;
  logic [PRESC_W-1:0]     Prescale;
  logic                   par_err;
  logic [DATA_LENGTH-1:0] P_DATA_par_chk;
  logic                   par_chk_en;
  logic                   sample_bit_par_chk;
  logic                   data_valid;
  logic                   stp_err;
  logic                   strt_glitch;
  logic                   busy;

  modport master (
    output RX_IN, PAR_EN, Prescale, par_err,
    input  P_DATA_par_chk, par_chk_en, sample_bit_par_chk,
    input  data_valid, stp_err, strt_glitch, busy
  );

  modport slave (
    input  RX_IN, PAR_EN, Prescale, par_err,
    output P_DATA_par_chk, par_chk_en, sample_bit_par_chk,
    output data_valid, stp_err, strt_glitch, busy
  );

endinterface

// File: rtl/uart_rx_ctrl_rx_edge_bit_counter.sv
// Oversampling edge counter and bit counter; both idle at zero while disabled.
module rx_edge_bit_counter #(
  parameter int unsigned PRESC_W = 6,
  parameter int unsigned BIT_W   = 4
) (
  input  logic               CLK_par,
  input  logic               RST_par,
  input  logic               en,
  input  logic               bit_clr,
  input  logic [PRESC_W-1:0] presc_q,
  output logic [PRESC_W-1:0] edge_cnt,
  output logic [BIT_W-1:0]   bit_cnt,
  output logic               bit_end_c
);

  assign bit_end_c = en && (edge_cnt == presc_q - PRESC_W'(1));

  always_ff @(posedge CLK_par or negedge RST_par) begin
    if (!RST_par) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (!en) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      edge_cnt <= bit_end_c ? '0 : edge_cnt + PRESC_W'(1);
      if (bit_clr)        bit_cnt <= '0;
      else if (bit_end_c) bit_cnt <= bit_cnt + BIT_W'(1);
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive front end: start detection, 3-sample majority vote, LSB-first
// deserialisation and start/stop framing checks feeding an external parity checker.
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_LENGTH = DATA_LENGTH_DEF,
  parameter int unsigned PRESC_W     = PRESC_W_DEF
) (
  input  logic     CLK_par,
  input  logic     RST_par,
  uart_rx_if.slave bus
);

  localparam int unsigned BIT_W = $clog2(DATA_LENGTH + 4);

  rx_state_e              state, state_nxt;
  logic [PRESC_W-1:0]     presc_q, presc_d, edge_cnt, h_lo, h_mid, h_hi;
  logic [BIT_W-1:0]       bit_cnt;
  logic                   bit_end_c, bit_clr_c, cnt_en_c, last_bit_c;
  logic                   par_en_q, par_en_d;
  logic                   samp_lo, samp_mid, sampled_bit, maj_c, bit_val_c;
  logic [DATA_LENGTH-1:0] p_data_q, p_data_d;
  logic                   par_chk_en_q, par_chk_en_d, sample_bit_q, sample_bit_d;
  logic                   data_valid_q, data_valid_d, stp_err_q, stp_err_d;
  logic                   strt_glitch_q, strt_glitch_d, busy_q;

  assign cnt_en_c = (state != IDLE);

  rx_edge_bit_counter #(.PRESC_W(PRESC_W), .BIT_W(BIT_W)) u_cnt (
    .CLK_par   (CLK_par),
    .RST_par   (RST_par),
    .en        (cnt_en_c),
    .bit_clr   (bit_clr_c),
    .presc_q   (presc_q),
    .edge_cnt  (edge_cnt),
    .bit_cnt   (bit_cnt),
    .bit_end_c (bit_end_c)
  );

  // Vote window centred on the middle of the bit; at the last sample edge the
  // fresh vote is forwarded so short prescales still see the current bit.
  assign h_mid      = presc_q >> 1;
  assign h_lo       = h_mid - PRESC_W'(1);
  assign h_hi       = h_mid + PRESC_W'(1);
  assign maj_c      = (samp_lo & samp_mid) | (samp_lo & bus.RX_IN) | (samp_mid & bus.RX_IN);
  assign bit_val_c  = (edge_cnt == h_hi) ? maj_c : sampled_bit;
  assign last_bit_c = (bit_cnt == BIT_W'(DATA_LENGTH - 1));

  always_ff @(posedge CLK_par or negedge RST_par) begin
    if (!RST_par) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (!bus.RX_IN && (bus.Prescale >= PRESC_W'(MIN_PRESCALE))) state_nxt = START;
      START:  if (bit_end_c) state_nxt = bit_val_c ? IDLE : DATA;
      DATA:   if (bit_end_c && last_bit_c) state_nxt = bus.PAR_EN ? PARITY : STOP;
      PARITY: if (bit_end_c) state_nxt = STOP;
      STOP:   if (bit_end_c) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    presc_d       = presc_q;
    par_en_d      = par_en_q;
    p_data_d      = p_data_q;
    stp_err_d     = stp_err_q;
    bit_clr_c     = 1'b0;
    strt_glitch_d = 1'b0;
    par_chk_en_d  = 1'b0;
    sample_bit_d  = 1'b0;
    data_valid_d  = 1'b0;
    case (state)
      IDLE: if (!bus.RX_IN) presc_d = bus.Prescale;
      START: begin
        if (bit_end_c && !bit_val_c) begin
          p_data_d  = '0;
          bit_clr_c = 1'b1;
        end else if (bit_end_c) begin
          strt_glitch_d = 1'b1;
        end
      end
      DATA: begin
        if (bit_end_c) begin
          for (int unsigned i = 0; i < DATA_LENGTH; i++) begin
            if (bit_cnt == BIT_W'(i)) p_data_d[i] = bit_val_c;
          end
          if (last_bit_c) par_en_d = bus.PAR_EN;
        end
      end
      // Strobe is raised one edge early so it is high during the bit-end cycle itself.
      PARITY: begin
        if (edge_cnt == presc_q - PRESC_W'(2)) begin
          par_chk_en_d = 1'b1;
          sample_bit_d = bit_val_c;
        end
      end
      STOP: begin
        if (bit_end_c) begin
          stp_err_d    = ~bit_val_c;
          data_valid_d = bit_val_c & ~(par_en_q & bus.par_err);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK_par or negedge RST_par) begin
    if (!RST_par) begin
      presc_q       <= '0;
      par_en_q      <= 1'b0;
      samp_lo       <= 1'b0;
      samp_mid      <= 1'b0;
      sampled_bit   <= 1'b0;
      p_data_q      <= '0;
      par_chk_en_q  <= 1'b0;
      sample_bit_q  <= 1'b0;
      data_valid_q  <= 1'b0;
      stp_err_q     <= 1'b0;
      strt_glitch_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      presc_q       <= presc_d;
      par_en_q      <= par_en_d;
      p_data_q      <= p_data_d;
      par_chk_en_q  <= par_chk_en_d;
      sample_bit_q  <= sample_bit_d;
      data_valid_q  <= data_valid_d;
      stp_err_q     <= stp_err_d;
      strt_glitch_q <= strt_glitch_d;
      busy_q        <= (state_nxt != IDLE);
      if (state != IDLE) begin
        if (edge_cnt == h_lo)  samp_lo     <= bus.RX_IN;
        if (edge_cnt == h_mid) samp_mid    <= bus.RX_IN;
        if (edge_cnt == h_hi)  sampled_bit <= maj_c;
      end
    end
  end

  assign bus.P_DATA_par_chk     = p_data_q;
  assign bus.par_chk_en         = par_chk_en_q;
  assign bus.sample_bit_par_chk = sample_bit_q;
  assign bus.data_valid         = data_valid_q;
  assign bus.stp_err            = stp_err_q;
  assign bus.strt_glitch        = strt_glitch_q;
  assign bus.busy               = busy_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: frames are queued as they are driven and
// checked by a monitor each time the receiver drops busy.
module tb_uart_rx_ctrl;

  localparam int unsigned DL = 8;
  localparam int unsigned PW = 6;

  typedef struct {
    bit         glitch;
    logic [7:0] data;
    bit         par_en;
    bit         par_bit;
    bit         stop_bit;
    int         presc;
  } frame_t;

  logic CLK_par = 1'b0;
  logic RST_par = 1'b1;

  uart_rx_if #(.DATA_LENGTH(DL), .PRESC_W(PW)) bus ();

  uart_rx_ctrl #(.DATA_LENGTH(DL), .PRESC_W(PW)) dut (
    .CLK_par (CLK_par),
    .RST_par (RST_par),
    .bus     (bus)
  );

  always #5 CLK_par = ~CLK_par;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  frame_t     exp_q[$];
  logic [7:0] exp_pdata = 8'h00;
  bit         exp_stp   = 1'b0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endfunction

  always @(posedge CLK_par) cyc++;

  // Even-parity checker model with a registered error flag.
  always @(posedge CLK_par or negedge RST_par) begin
    if (!RST_par)           bus.par_err <= 1'b0;
    else if (bus.par_chk_en) bus.par_err <= (^bus.P_DATA_par_chk) ^ bus.sample_bit_par_chk;
  end

  // Monitor: every busy fall ends one queued frame.
  bit     busy_prev = 1'b0;
  int     rise_cyc  = 0;
  int     par_pulses = 0;
  frame_t cur;
  bit     frame_end;
  bit     e_dv, e_gl, e_stp, p_bad;
  logic [7:0] e_pd;
  int     e_pulses, e_dur;

  always @(negedge CLK_par) begin
    if (!RST_par) begin
      busy_prev  = 1'b0;
      par_pulses = 0;
    end else begin
      if (bus.busy && !busy_prev) begin
        rise_cyc   = cyc;
        par_pulses = 0;
      end
      if (bus.par_chk_en) begin
        par_pulses++;
        if (exp_q.size() > 0) chk("par_sample_bit", 32'(bus.sample_bit_par_chk), 32'(exp_q[0].par_bit));
      end
      frame_end = busy_prev && !bus.busy;
      if (!frame_end && (bus.data_valid || bus.strt_glitch)) begin
        n_checks++;
        n_fail++;
        $display("FAIL stray_pulse: dv=%0b glitch=%0b outside frame end (cycle %0d)",
                 bus.data_valid, bus.strt_glitch, cyc);
      end
      if (frame_end) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_frame: busy fell with empty queue (cycle %0d)", cyc);
        end else begin
          cur = exp_q.pop_front();
          if (cur.glitch) begin
            e_gl = 1'b1; e_dv = 1'b0; e_stp = exp_stp; e_pd = exp_pdata;
            e_pulses = 0; e_dur = cur.presc;
          end else begin
            p_bad    = cur.par_en && ((^cur.data) != cur.par_bit);
            e_gl     = 1'b0;
            e_dv     = cur.stop_bit && !p_bad;
            e_stp    = !cur.stop_bit;
            e_pd     = cur.data;
            e_pulses = cur.par_en ? 1 : 0;
            e_dur    = (10 + (cur.par_en ? 1 : 0)) * cur.presc;
          end
          exp_stp   = e_stp;
          exp_pdata = e_pd;
          chk("data_valid",  32'(bus.data_valid),     32'(e_dv));
          chk("strt_glitch", 32'(bus.strt_glitch),    32'(e_gl));
          chk("stp_err",     32'(bus.stp_err),        32'(e_stp));
          chk("p_data",      32'(bus.P_DATA_par_chk), 32'(e_pd));
          chk("par_chk_cnt", 32'(par_pulses),         32'(e_pulses));
          chk("frame_len",   32'(cyc - rise_cyc),     32'(e_dur));
        end
      end
      busy_prev = bus.busy;
    end
  end

  function automatic int rand_presc();
    int sel;
    sel = int'($urandom_range(0, 2));
    return 8 << sel;
  endfunction

  // Drives one frame; abort_at > 0 stops after that many frame cycles and queues nothing.
  task automatic drive_frame(input int presc, input bit par_en, input logic [7:0] data,
                             input bit par_bit, input bit stop_bit, input int gap,
                             input int abort_at);
    bit     fb[$];
    frame_t f;
    int     k;
    f.glitch = 1'b0; f.data = data; f.par_en = par_en;
    f.par_bit = par_bit; f.stop_bit = stop_bit; f.presc = presc;
    if (abort_at == 0) exp_q.push_back(f);
    fb.push_back(1'b0);
    for (int i = 0; i < 8; i++) fb.push_back(data[i]);
    if (par_en) fb.push_back(par_bit);
    fb.push_back(stop_bit);
    repeat (gap) begin
      @(negedge CLK_par);
      bus.RX_IN = 1'b1;
    end
    k = 0;
    for (int b = 0; b < fb.size(); b++) begin
      for (int c = 0; c < presc; c++) begin
        @(negedge CLK_par);
        bus.RX_IN = fb[b];
        if (b == 0 && c == 0) begin
          bus.Prescale = PW'(presc);
          bus.PAR_EN   = 1'($urandom);
        end
        if (b == 0 && c == 2)      bus.Prescale = PW'(rand_presc());
        if (b == 1 && c == 0)      bus.PAR_EN = par_en;
        if (b == DL + 1 && c == 2) bus.PAR_EN = 1'($urandom);
        k++;
        if (abort_at != 0 && k == abort_at) return;
      end
    end
  endtask

  task automatic drive_glitch(input int presc, input int low_len, input int gap);
    frame_t f;
    f.glitch = 1'b1; f.data = 8'h00; f.par_en = 1'b0;
    f.par_bit = 1'b0; f.stop_bit = 1'b1; f.presc = presc;
    exp_q.push_back(f);
    repeat (gap) begin
      @(negedge CLK_par);
      bus.RX_IN = 1'b1;
    end
    for (int c = 0; c < low_len; c++) begin
      @(negedge CLK_par);
      bus.RX_IN = 1'b0;
      if (c == 0) bus.Prescale = PW'(presc);
    end
    repeat (presc + 2) begin
      @(negedge CLK_par);
      bus.RX_IN = 1'b1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_p_data"},      32'(bus.P_DATA_par_chk),     32'h0);
    chk({tag, "_par_chk_en"},  32'(bus.par_chk_en),         32'h0);
    chk({tag, "_sample_bit"},  32'(bus.sample_bit_par_chk), 32'h0);
    chk({tag, "_data_valid"},  32'(bus.data_valid),         32'h0);
    chk({tag, "_stp_err"},     32'(bus.stp_err),            32'h0);
    chk({tag, "_strt_glitch"}, 32'(bus.strt_glitch),        32'h0);
    chk({tag, "_busy"},        32'(bus.busy),               32'h0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int         presc, gap;
    bit         pe, perr, stp, gl;
    logic [7:0] d;

    bus.RX_IN    = 1'b1;
    bus.PAR_EN   = 1'b0;
    bus.Prescale = PW'(8);
    #3 RST_par = 1'b0;
    repeat (3) @(posedge CLK_par);
    #1 check_reset_outputs("reset");
    @(negedge CLK_par);
    RST_par = 1'b1;

    drive_frame(8, 1'b1, 8'hA5, 1'b0, 1'b1, 3, 0);
    drive_frame(16, 1'b0, 8'h3C, 1'b0, 1'b1, 2, 0);
    drive_frame(16, 1'b0, 8'hFF, 1'b0, 1'b1, 0, 0);
    drive_glitch(8, 2, 3);
    drive_frame(8, 1'b0, 8'h5A, 1'b0, 1'b0, 2, 0);
    drive_frame(8, 1'b0, 8'h11, 1'b0, 1'b1, 2, 0);
    drive_frame(8, 1'b1, 8'h0F, 1'b1, 1'b1, 2, 0);

    // Abort a 0x81 frame inside its fourth data bit.
    drive_frame(8, 1'b0, 8'h81, 1'b0, 1'b1, 3, 8 + 3 * 8 + 4);
    #2 RST_par = 1'b0;
    #1 check_reset_outputs("midframe_reset");
    bus.RX_IN = 1'b1;
    exp_pdata = 8'h00;
    exp_stp   = 1'b0;
    repeat (3) @(negedge CLK_par);
    RST_par = 1'b1;
    drive_frame(8, 1'b0, 8'h81, 1'b0, 1'b1, 3, 0);

    for (int n = 0; n < 30; n++) begin
      presc = rand_presc();
      gap   = int'($urandom_range(2, 5));
      gl    = ($urandom_range(0, 7) == 0);
      if (gl) begin
        drive_glitch(presc, int'($urandom_range(1, presc / 2 - 1)), gap);
      end else begin
        d    = 8'($urandom);
        pe   = 1'($urandom);
        perr = ($urandom_range(0, 4) == 0);
        stp  = ($urandom_range(0, 5) != 0);
        drive_frame(presc, pe, d, (^d) ^ perr, stp, gap, 0);
      end
    end
    @(negedge CLK_par);
    bus.RX_IN = 1'b1;

    for (int i = 0; i < 3000 && exp_q.size() > 0; i++) @(negedge CLK_par);
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d frames still pending, required 0", exp_q.size());
    end
    repeat (5) @(negedge CLK_par);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
UART receive front end: start detection, bit timing, 3-sample majority vote, LSB-first deserialization, and start/stop framing checks.
Drives the downstream parity checker with P_DATA_par_chk, par_chk_en and sample_bit_par_chk, and consumes its registered par_err.
Emits one data_valid pulse per clean frame.
Single clock domain CLK_par; the RX_IN synchroniser sits outside this block.

Parameters:
DATA_LENGTH, 8, payload bits per frame
PRESC_W, 6, width of Prescale input and edge counter

Ports:
CLK_par  in  1  receive oversampling clock
RST_par  in  1  reset, asynchronous, active-low
RX_IN  in  1  synchronised serial line, idle high
PAR_EN  in  1  1 = frame carries a parity bit
Prescale  in  PRESC_W  oversampling ratio; legal values 8, 16, 32
par_err  in  1  registered parity error from the parity checker
P_DATA_par_chk  out  DATA_LENGTH  received payload
par_chk_en  out  1  one-cycle strobe to the parity checker
sample_bit_par_chk  out  1  voted parity bit, valid while par_chk_en is high
data_valid  out  1  one-cycle pulse: frame accepted
stp_err  out  1  stop-bit error flag, registered
strt_glitch  out  1  one-cycle pulse: false start rejected
busy  out  1  high in every state except IDLE

Behaviour:
- Reset: all outputs 0, P_DATA_par_chk = 0, state = IDLE, counters 0. Reset is honoured mid-frame with immediate abort; no data_valid is produced for the aborted frame.
- Prescale is latched into presc_q on the IDLE->START transition and ignored for the rest of the frame. A latched value below 4 keeps the block in IDLE.
- edge_cnt: 0..presc_q-1, increments every cycle outside IDLE, wraps to 0 at presc_q-1. bit_cnt increments on each wrap.
- Majority vote: RX_IN sampled at edge_cnt = H-1, H, H+1, where H = presc_q/2. sampled_bit = majority of the 3 samples, registered at edge H+1 and held until the next bit.
- States: IDLE, START, DATA, PARITY, STOP. Decisions are taken at edge_cnt = presc_q-1, called "bit end" below.
- IDLE: RX_IN = 0 -> START with edge_cnt = 0, bit_cnt = 0.
- START, bit end: sampled_bit = 0 -> DATA. sampled_bit = 1 -> strt_glitch pulse, go to IDLE.
- DATA, bit end: P_DATA_par_chk[bit_cnt] <= sampled_bit (LSB first). After bit DATA_LENGTH-1: PAR_EN = 1 -> PARITY, else STOP.
- P_DATA_par_chk is cleared on the START->DATA transition and held stable after the last data bit until the next frame enters DATA.
- PARITY, bit end: par_chk_en = 1 for exactly one cycle, sample_bit_par_chk = sampled_bit in that cycle, then -> STOP. The checker's par_err is valid from the next cycle and stays stable through STOP.
- STOP, bit end:
  - stp_err <= ~sampled_bit.
  - data_valid = 1 for one cycle iff sampled_bit = 1 and !(PAR_EN & par_err).
  - Next state IDLE. RX_IN = 0 in the following cycle starts a new frame; back-to-back frames are supported with a 1-cycle realignment.
- PAR_EN is sampled only at the DATA bit end of the last data bit. Changes at any other time in the frame have no effect.
- stp_err is held until the next STOP bit end. par_chk_en is 0 in every state except PARITY.
- Frame length: (1 + DATA_LENGTH + PAR_EN + 1) * presc_q cycles, plus 1 cycle of IDLE detection.

Decomposition:
- Shared package uart_rx_pkg:
  - state enum / localparams IDLE=0, START=1, DATA=2, PARITY=3, STOP=4 (3-bit encoding)
  - MIN_PRESCALE = 4
  - default DATA_LENGTH
- One sub-module, rx_edge_bit_counter: edge_cnt/bit_cnt with enable, wrap and presc_q input.
- Majority vote, deserializer shift and FSM stay in the top level.

Test Plan:
- Prescale = 8, PAR_EN = 1, even parity, byte 0xA5 sent as bits 1,0,1,0,0,1,0,1, parity 0, stop 1 -> P_DATA_par_chk = 0xA5, exactly one par_chk_en with sample_bit_par_chk = 0, data_valid pulse at the STOP bit end (cycle 88 after the start edge), stp_err = 0.
- Prescale = 16, PAR_EN = 0, byte 0x3C then back-to-back byte 0xFF -> two data_valid pulses with P_DATA 0x3C then 0xFF, par_chk_en never asserted.
- Prescale = 8, RX_IN low for 2 cycles only (glitch) -> strt_glitch pulse at edge 7, return to IDLE, no data_valid, busy drops.
- Prescale = 8, byte 0x5A with stop bit driven 0 -> stp_err = 1, no data_valid. Next clean frame 0x11 -> stp_err = 0, data_valid.
- PAR_EN = 1, wrong parity bit, model checker returns par_err = 1 the cycle after par_chk_en -> no data_valid, P_DATA still 0x0F for sent 0x0F.
- RST_par asserted in the 4th DATA bit of byte 0x81 -> all outputs 0 immediately. After release a fresh 0x81 frame yields data_valid with P_DATA 0x81.
